// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider and its ratio detector:
// select codes, legal periods and the detector state type.
package clk_div_pkg;

    localparam logic [2:0] SEL_DIV2  = 3'b000;
    localparam logic [2:0] SEL_DIV4  = 3'b001;
    localparam logic [2:0] SEL_DIV8  = 3'b010;
    localparam logic [2:0] SEL_DIV16 = 3'b011;

    localparam int unsigned PER_DIV2  = 2;
    localparam int unsigned PER_DIV4  = 4;
    localparam int unsigned PER_DIV8  = 8;
    localparam int unsigned PER_DIV16 = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        LOCKING,
        LOCKED,
        STALLED
    } det_state_t;

    typedef struct packed {
        logic       legal;
        logic [2:0] code;
    } period_dec_t;

    function automatic period_dec_t decode_period(input int unsigned per);
        period_dec_t d;
        d.legal = 1'b1;
        d.code  = SEL_DIV2;
        case (per)
            PER_DIV2:  d.code = SEL_DIV2;
            PER_DIV4:  d.code = SEL_DIV4;
            PER_DIV8:  d.code = SEL_DIV8;
            PER_DIV16: d.code = SEL_DIV16;
            default:   d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a registered rising-edge pulse;
// input rise to pulse is three i_clk cycles.
module sync_edge_detect (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_d,
    output logic o_rise
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            o_rise <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], i_d};
            prev_q <= sync_q[1];
            o_rise <= sync_q[1] & ~prev_q;
        end
    end

endmodule

// File: rtl/clock_ratio_detector.sv
// Recovers the divider select code from the divided clock waveform by
// timing rising edges against i_clk and locking on repeated legal periods.
module clock_ratio_detector
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = 6,
    parameter int TIMEOUT  = 32,
    parameter int STABLE_N = 2
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_meas_clk,
    output logic [2:0]       o_sel,
    output logic             o_valid,
    output logic             o_stall,
    output logic [CNT_W-1:0] o_period,
    output logic             o_change
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_TO     = CNT_W'(TIMEOUT);
    localparam logic [3:0]       STABLE_TGT = 4'(STABLE_N);

    logic             edge_p;
    logic [CNT_W-1:0] cnt;
    logic             timeout;
    period_dec_t      dec;

    det_state_t       state, state_d;
    logic [3:0]       stable, stable_d;
    logic [2:0]       cand, cand_d;
    logic             have_lock, have_lock_d;
    logic             lock_en;

    logic [2:0]       sel_d;
    logic             valid_d;
    logic             stall_d;
    logic [CNT_W-1:0] period_d;
    logic             change_d;

    sync_edge_detect u_sync (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .i_d      (i_meas_clk),
        .o_rise   (edge_p)
    );

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            cnt <= '0;
        end else if (edge_p) begin
            cnt <= CNT_W'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign dec     = decode_period(32'(cnt));
    assign timeout = (cnt == CNT_TO) && !edge_p;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state     <= IDLE;
            stable    <= '0;
            cand      <= SEL_DIV2;
            have_lock <= 1'b0;
            o_sel     <= SEL_DIV2;
            o_valid   <= 1'b0;
            o_stall   <= 1'b0;
            o_period  <= '0;
            o_change  <= 1'b0;
        end else begin
            state     <= state_d;
            stable    <= stable_d;
            cand      <= cand_d;
            have_lock <= have_lock_d;
            o_sel     <= sel_d;
            o_valid   <= valid_d;
            o_stall   <= stall_d;
            o_period  <= period_d;
            o_change  <= change_d;
        end
    end

    always_comb begin
        state_d     = state;
        stable_d    = stable;
        cand_d      = cand;
        have_lock_d = have_lock;
        sel_d       = o_sel;
        valid_d     = o_valid;
        stall_d     = o_stall;
        period_d    = o_period;
        change_d    = 1'b0;
        lock_en     = 1'b0;

        if (edge_p) begin
            unique case (state)
                IDLE, STALLED: begin
                    state_d = ARMED;
                    stall_d = 1'b0;
                end
                ARMED, LOCKING, LOCKED: begin
                    period_d = cnt;
                    if (!dec.legal) begin
                        state_d = ARMED;
                        valid_d = 1'b0;
                    end else if (state != ARMED && dec.code == cand) begin
                        if (state == LOCKING) begin
                            stable_d = stable + 4'd1;
                            lock_en  = (stable + 4'd1) >= STABLE_TGT;
                        end
                    end else begin
                        // New candidate ratio; a single period suffices when STABLE_N is 1
                        state_d  = LOCKING;
                        stable_d = 4'd1;
                        cand_d   = dec.code;
                        valid_d  = 1'b0;
                        lock_en  = (STABLE_N == 1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout && state != IDLE) begin
            state_d  = STALLED;
            stall_d  = 1'b1;
            valid_d  = 1'b0;
            stable_d = '0;
        end

        if (lock_en) begin
            state_d     = LOCKED;
            valid_d     = 1'b1;
            sel_d       = cand_d;
            change_d    = have_lock && (cand_d != o_sel);
            have_lock_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_clock_ratio_detector.sv
// Directed and randomized bench for clock_ratio_detector against an
// edge-timing reference model; runs STABLE_N = 2 and STABLE_N = 1 side by side.
module tb_clock_ratio_detector;
    import clk_div_pkg::*;

    localparam int CNT_W   = 6;
    localparam int TIMEOUT = 32;

    logic             i_clk      = 1'b0;
    logic             i_resetn   = 1'b0;
    logic             i_meas_clk = 1'b0;
    logic [2:0]       o_sel    [2];
    logic             o_valid  [2];
    logic             o_stall  [2];
    logic [CNT_W-1:0] o_period [2];
    logic             o_change [2];

    clock_ratio_detector #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .STABLE_N(2)) u_dut (
        .i_clk      (i_clk),
        .i_resetn   (i_resetn),
        .i_meas_clk (i_meas_clk),
        .o_sel      (o_sel[0]),
        .o_valid    (o_valid[0]),
        .o_stall    (o_stall[0]),
        .o_period   (o_period[0]),
        .o_change   (o_change[0])
    );

    clock_ratio_detector #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .STABLE_N(1)) u_dut_sn1 (
        .i_clk      (i_clk),
        .i_resetn   (i_resetn),
        .i_meas_clk (i_meas_clk),
        .o_sel      (o_sel[1]),
        .o_valid    (o_valid[1]),
        .o_stall    (o_stall[1]),
        .o_period   (o_period[1]),
        .o_change   (o_change[1])
    );

    always #5 i_clk = ~i_clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit pm      = 1'b0;
    int evq[$];
    int n_change[2];

    bit         m_ref  [2];
    bit         m_ever [2];
    int         m_last [2];
    int         m_run  [2];
    int         m_runp [2];
    logic [2:0] e_sel    [2];
    bit         e_valid  [2];
    bit         e_stall  [2];
    bit         e_change [2];
    int         e_period [2];

    function automatic bit is_legal(input int p);
        for (int i = 0; i < 4; i++) if (p == (2 << i)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] code_of(input int p);
        for (int i = 0; i < 4; i++) if (p == (2 << i)) return 3'(i);
        return 3'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    endtask

    // Lock = a run of STABLE_N identical legal periods since the last arming edge
    task automatic model_inst(input int k, input bit ev);
        int sn;
        int p;
        logic [2:0] c;
        bit lk;
        sn = (k == 0) ? 2 : 1;
        e_change[k] = 1'b0;
        if (ev) begin
            if (!m_ref[k]) begin
                m_ref[k]   = 1'b1;
                e_stall[k] = 1'b0;
                m_run[k]   = 0;
            end else begin
                p = cyc - m_last[k];
                e_period[k] = p;
                if (!is_legal(p)) m_run[k] = 0;
                else if (m_run[k] > 0 && p == m_runp[k]) m_run[k]++;
                else begin
                    m_run[k]  = 1;
                    m_runp[k] = p;
                end
                c  = code_of(p);
                lk = is_legal(p) && m_run[k] >= sn;
                if (lk && (!e_valid[k] || c != e_sel[k])) begin
                    e_change[k] = m_ever[k] && (c != e_sel[k]);
                    e_sel[k]    = c;
                    m_ever[k]   = 1'b1;
                end
                e_valid[k] = lk;
            end
            m_last[k] = cyc;
        end else if (m_ref[k] && cyc - m_last[k] == TIMEOUT) begin
            m_ref[k]   = 1'b0;
            e_stall[k] = 1'b1;
            e_valid[k] = 1'b0;
            m_run[k]   = 0;
        end
    endtask

    task automatic model_step(input bit rst, input bit mv);
        bit ev;
        if (rst) begin
            evq.delete();
            pm = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_ref[k] = 1'b0; m_ever[k] = 1'b0; m_run[k] = 0;
                e_sel[k] = 3'd0; e_valid[k] = 1'b0; e_stall[k] = 1'b0;
                e_change[k] = 1'b0; e_period[k] = 0;
            end
            return;
        end
        ev = 1'b0;
        if (evq.size() > 0 && evq[0] == cyc) begin
            ev = 1'b1;
            void'(evq.pop_front());
        end
        if (mv && !pm) evq.push_back(cyc + 3);
        pm = mv;
        for (int k = 0; k < 2; k++) model_inst(k, ev);
    endtask

    task automatic tick(input bit mv, input bit rst);
        @(negedge i_clk);
        i_meas_clk = mv;
        i_resetn   = !rst;
        @(posedge i_clk);
        cyc++;
        model_step(rst, mv);
        #1;
        for (int k = 0; k < 2; k++) begin
            check(k == 0 ? "sel_sn2" : "sel_sn1", 32'(o_sel[k]), 32'(e_sel[k]));
            check(k == 0 ? "valid_sn2" : "valid_sn1", 32'(o_valid[k]), 32'(e_valid[k]));
            check(k == 0 ? "stall_sn2" : "stall_sn1", 32'(o_stall[k]), 32'(e_stall[k]));
            check(k == 0 ? "period_sn2" : "period_sn1", 32'(o_period[k]), e_period[k]);
            check(k == 0 ? "change_sn2" : "change_sn1", 32'(o_change[k]), 32'(e_change[k]));
            if (o_change[k] === 1'b1) n_change[k]++;
        end
    endtask

    task automatic run_per(input int p, input int n);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < p; j++) tick(j < p / 2, 1'b0);
    endtask

    task automatic hold(input bit v, input int n);
        for (int i = 0; i < n; i++) tick(v, 1'b0);
    endtask

    task automatic do_reset();
        hold(1'b0, 4);
        tick(1'b0, 1'b1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sel"}, 32'(o_sel[0]), 32'(SEL_DIV2));
        check({tag, "_valid"}, 32'(o_valid[0]), 0);
        check({tag, "_stall"}, 32'(o_stall[0]), 0);
        check({tag, "_period"}, 32'(o_period[0]), 0);
        check({tag, "_change"}, 32'(o_change[0]), 0);
    endtask

    initial begin
        int ill[6];
        int r;
        ill = '{3, 5, 6, 7, 12, 24};
        n_change = '{0, 0};

        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        check_reset_vals("por");

        run_per(4, 6);
        check("div4_sel", 32'(o_sel[0]), 32'(SEL_DIV4));
        check("div4_valid", 32'(o_valid[0]), 1);
        check("div4_period", 32'(o_period[0]), 4);
        check("div4_no_change", n_change[0], 0);

        run_per(2, 8);
        n_change[0] = 0;
        run_per(16, 3);
        check("div16_sel", 32'(o_sel[0]), 32'(SEL_DIV16));
        check("div16_valid", 32'(o_valid[0]), 1);
        check("div16_one_change", n_change[0], 1);

        hold(1'b0, 40);
        check("low_stall", 32'(o_stall[0]), 1);
        check("low_valid", 32'(o_valid[0]), 0);
        run_per(4, 4);
        check("unstall_stall", 32'(o_stall[0]), 0);
        check("unstall_valid", 32'(o_valid[0]), 1);

        hold(1'b1, 40);
        check("div1_stall", 32'(o_stall[0]), 1);
        run_per(8, 4);
        check("div8_sel", 32'(o_sel[0]), 32'(SEL_DIV8));
        check("div8_valid", 32'(o_valid[0]), 1);

        run_per(6, 1);
        run_per(8, 1);
        check("illegal_valid", 32'(o_valid[0]), 0);
        check("illegal_sel_hold", 32'(o_sel[0]), 32'(SEL_DIV8));
        check("illegal_period", 32'(o_period[0]), 6);
        run_per(8, 3);
        check("relock8_valid", 32'(o_valid[0]), 1);

        run_per(32, 3);
        check("gap32_stall", 32'(o_stall[0]), 0);
        check("gap32_valid", 32'(o_valid[0]), 0);
        run_per(33, 3);
        hold(1'b0, 30);
        check("gap33_stall", 32'(o_stall[0]), 1);

        run_per(8, 4);
        do_reset();
        check_reset_vals("midrst");
        n_change[0] = 0;
        run_per(4, 5);
        check("rst_relock_sel", 32'(o_sel[0]), 32'(SEL_DIV4));
        check("rst_relock_valid", 32'(o_valid[0]), 1);
        check("rst_relock_no_change", n_change[0], 0);

        do_reset();
        run_per(8, 2);
        check("sn1_valid", 32'(o_valid[1]), 1);
        check("sn1_period", 32'(o_period[1]), 8);
        check("sn1_sel", 32'(o_sel[1]), 32'(SEL_DIV8));
        check("sn2_not_yet", 32'(o_valid[0]), 0);

        for (int s = 0; s < 60; s++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) run_per(2 << $urandom_range(0, 3), $urandom_range(1, 5));
            else if (r == 6) run_per(ill[$urandom_range(0, 5)], 1);
            else if (r == 7) hold(1'($urandom_range(0, 1)), $urandom_range(10, 45));
            else if (r == 8) do_reset();
            else for (int i = 0; i < 12; i++) tick(1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/clock_ratio_detector.md
# clock_ratio_detector

Monitors a divided clock produced by the synchronous clock divider, treating it as data sampled by the master clock, and reports which divide ratio is currently selected. It is the read side of the divider's select interface: it recovers the 3-bit select code from the clock waveform alone. It sits in the clock-control subsystem for mux-switch verification and on-chip health reporting.

## Interface
- CNT_W, 6: width of the period counter and `o_period`.
- TIMEOUT, 32: cycles without a rising edge before stall is declared.
  - Must satisfy 16 < TIMEOUT < 2^CNT_W.
- STABLE_N, 2: consecutive identical legal periods required for lock; range 1..15.

Ports:
- i_clk  in  1  master clock; same clock that feeds the divider.
- i_resetn  in  1  synchronous, active-low reset.
- i_meas_clk  in  1  divided clock under measurement; sampled as data.
- o_sel  out  3  recovered select code.
  - 000 = /2, 001 = /4, 010 = /8, 011 = /16; other codes are never driven.
- o_valid  out  1  `o_sel` is locked and trustworthy.
- o_stall  out  1  no edge seen within TIMEOUT.
  - Covers a stopped clock or the undivided (/1) selection, which cannot be sampled by i_clk.
- o_period  out  CNT_W  last measured edge-to-edge period, in i_clk cycles.
- o_change  out  1  one-cycle pulse when a locked `o_sel` changes value.

## Operation
- Front end:
  - 2-FF synchronizer on `i_meas_clk`, then a registered rising-edge detector producing pulse `edge_p`.
  - Latency from input rise to `edge_p` is 3 cycles.
- Period counter `cnt`:
  - On `edge_p`, `cnt <= 1`.
  - Otherwise `cnt <= cnt + 1`, saturating at 2^CNT_W − 1.
- Measurement: on `edge_p` in state ARMED/LOCKING/LOCKED, `meas = cnt`; `o_period <= meas`.
- Legal periods and decode: 2→000, 4→001, 8→010, 16→011. Any other value is illegal.
- State machine (one-hot or enum):
  - IDLE, entered from reset: first `edge_p` → ARMED. No measurement is taken on this edge.
  - ARMED: `edge_p` with a legal period → LOCKING, `stable = 1`, `cand = code`. Illegal period → stay ARMED.
  - LOCKING: `edge_p` with a legal period equal to the previous period → `stable++`.
    - When `stable` reaches STABLE_N → LOCKED, `o_valid <= 1`, `o_sel <= cand`.
    - Legal but different period → `stable = 1`, `cand = new`.
    - Illegal period → ARMED.
  - LOCKED:
    - Same period → stay.
    - Different legal period → LOCKING, `o_valid <= 0`, `stable = 1`, `cand = new`.
    - Illegal period → ARMED, `o_valid <= 0`.
  - STALLED: `o_stall = 1`, `o_valid = 0`. Next `edge_p` → ARMED and clears `o_stall`.
- From any state other than IDLE, `cnt == TIMEOUT` without `edge_p` → STALLED.
- `o_sel` holds its last locked value while `o_valid = 0`. It is updated only on entry to LOCKED.
- `o_change` pulses on entry to LOCKED when the new `o_sel` differs from the previously locked value. It does not pulse on the first lock after reset.

## Timing
- All outputs are registered. Reset values: `o_sel = 000`, `o_valid = 0`, `o_stall = 0`, `o_period = 0`, `o_change = 0`.
- Internal reset values: state = IDLE, `cnt = 0`, `stable = 0`.
- Lock latency with STABLE_N = 2 is 3 `edge_p` pulses after IDLE. Example at /4: pulses at t, t+4, t+8 → `o_valid` is high from t+9.
- Outputs update the cycle after the `edge_p` that causes them.
- `edge_p` and timeout in the same cycle: the edge wins and the timeout is ignored.
- Reset asserted mid-operation: all state returns to reset values on the next i_clk edge. The synchronizer flops also clear.
- Counter saturation must never wrap. This is guaranteed because TIMEOUT < 2^CNT_W.

## Structure
- Shared package `clk_div_pkg` holds:
  - Select-code constants SEL_DIV2/4/8/16 (shared with the divider's select encoding).
  - Legal period constants.
  - The state enum `det_state_t`.
- One sub-module, `sync_edge_detect`: 2-FF synchronizer plus rising-edge pulse, with a synchronous active-low reset.

## Test plan
- Drive the divider with i_sel = 001 (/4) into `i_meas_clk`:
  - `o_period` = 4.
  - `o_valid` rises 1 cycle after the third `edge_p`; `o_sel` = 001.
  - `o_stall` = 0 and `o_change` = 0 throughout.
- Locked at /2, then switch the divider to /16:
  - `o_valid` drops after the first 16-cycle period.
  - After the next matching period, `o_sel` = 011, `o_valid` = 1, and `o_change` pulses exactly once.
- Divider select = 1xx (/1) or `i_meas_clk` held low:
  - `o_stall` = 1 when `cnt` reaches 32; `o_valid` = 0.
  - The first edge afterwards clears `o_stall`; lock returns after 2 further periods.
- Inject an illegal period of 6 while locked at /8: `o_valid` = 0, `o_sel` holds 010, state ARMED. Relock follows after 2 legal periods.
- Assert i_resetn low for 1 cycle while locked at /4:
  - All outputs read reset values on the next cycle.
  - Relock requires 3 fresh edges, and `o_change` does not pulse on that relock.
- Set STABLE_N = 1: `o_valid` asserts after the second `edge_p` at /8, with `o_period` = 8.
